// File: rtl/rns_mod_alu.sv
// Modular add/sub/mul/zero ALU for one RNS residue channel, valid/ready in and out.
// Build option RNS_MOD_ALU_AUTO_REDUCE_EN: reduce out-of-range operands instead of flagging err.
module rns_mod_alu #(
  parameter int MOD = 13,
  parameter int W   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op_sel,
  input  logic [W-1:0] add_a,
  input  logic [W-1:0] sub_a,
  input  logic [W-1:0] mul_a,
  input  logic [W-1:0] zero_a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         err
);

  if (MOD < 2 || MOD > 15) begin : g_mod_chk
    $error("rns_mod_alu: MOD must be in 2..15");
  end

  localparam logic [4:0] M = 5'(MOD);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_ZERO = 2'b11;

`ifdef RNS_MOD_ALU_AUTO_REDUCE_EN
  typedef enum logic [1:0] {
    S_IDLE, S_CALC, S_DONE, S_REDUCE
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_CALC, S_DONE
  } state_t;
`endif

  state_t state, state_nx;

  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [1:0]   op_q, op_d;
  logic [1:0]   step_q, step_d;
  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] res_q, res_d;
  logic         err_q, err_d;
  logic         bad_q, bad_d;

  logic [W-1:0] a_sel;
  logic         in_bad;
  logic [4:0]   add_s, add_r;
  logic [4:0]   sub_d, sub_r;
  logic [4:0]   dbl, dbl_r, sum, mul_r;
  logic         mb;
`ifdef RNS_MOD_ALU_AUTO_REDUCE_EN
  logic [4:0]   ra, rb;
`endif

  always_comb begin
    a_sel = add_a;
    unique case (op_sel)
      OP_ADD:  a_sel = add_a;
      OP_SUB:  a_sel = sub_a;
      OP_MUL:  a_sel = mul_a;
      OP_ZERO: a_sel = zero_a;
      default: a_sel = add_a;
    endcase
  end

  assign in_bad = ({1'b0, a_sel} >= M) || ({1'b0, b} >= M);

  assign add_s = {1'b0, a_q} + {1'b0, b_q};
  assign add_r = (add_s >= M) ? add_s - M : add_s;
  assign sub_d = {1'b0, a_q} - {1'b0, b_q};
  assign sub_r = (a_q < b_q) ? sub_d + M : sub_d;

  // One MSB-first shift-add step: acc = (2*acc [+ a]) mod M
  assign mb    = b_q[2'd3 - step_q];
  assign dbl   = {acc_q, 1'b0};
  assign dbl_r = (dbl >= M) ? dbl - M : dbl;
  assign sum   = dbl_r + (mb ? {1'b0, a_q} : 5'd0);
  assign mul_r = (sum >= M) ? sum - M : sum;

`ifdef RNS_MOD_ALU_AUTO_REDUCE_EN
  assign ra = ({1'b0, a_q} >= M) ? {1'b0, a_q} - M : {1'b0, a_q};
  assign rb = ({1'b0, b_q} >= M) ? {1'b0, b_q} - M : {1'b0, b_q};
`endif

  always_comb begin
    state_nx = state;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    step_d   = step_q;
    acc_d    = acc_q;
    res_d    = res_q;
    err_d    = err_q;
    bad_d    = bad_q;
    unique case (state)
      S_IDLE: begin
        if (in_valid) begin
          a_d    = a_sel;
          b_d    = b;
          op_d   = op_sel;
          step_d = 2'd0;
          acc_d  = '0;
`ifdef RNS_MOD_ALU_AUTO_REDUCE_EN
          bad_d    = 1'b0;
          state_nx = in_bad ? S_REDUCE : S_CALC;
`else
          // Range fault is reported through CALC so it shares the 1-cycle latency
          bad_d    = in_bad;
          state_nx = S_CALC;
`endif
        end
      end
      S_CALC: begin
        if (bad_q) begin
          res_d    = '0;
          err_d    = 1'b1;
          state_nx = S_DONE;
        end else begin
          err_d = 1'b0;
          unique case (op_q)
            OP_ADD: begin
              res_d    = add_r[W-1:0];
              state_nx = S_DONE;
            end
            OP_SUB: begin
              res_d    = sub_r[W-1:0];
              state_nx = S_DONE;
            end
            OP_ZERO: begin
              res_d    = '0;
              state_nx = S_DONE;
            end
            OP_MUL: begin
              acc_d  = mul_r[W-1:0];
              step_d = step_q + 2'd1;
              if (step_q == 2'd3) begin
                res_d    = mul_r[W-1:0];
                state_nx = S_DONE;
              end
            end
            default: state_nx = S_DONE;
          endcase
        end
      end
      S_DONE: begin
        if (out_ready) state_nx = S_IDLE;
      end
`ifdef RNS_MOD_ALU_AUTO_REDUCE_EN
      S_REDUCE: begin
        a_d = ra[W-1:0];
        b_d = rb[W-1:0];
        if (ra < M && rb < M) state_nx = S_CALC;
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      step_q <= '0;
      acc_q  <= '0;
      res_q  <= '0;
      err_q  <= 1'b0;
      bad_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      step_q <= step_d;
      acc_q  <= acc_d;
      res_q  <= res_d;
      err_q  <= err_d;
      bad_q  <= bad_d;
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign result    = res_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rns_mod_alu.sv
// Directed self-checking bench for rns_mod_alu (MOD=13).
// Expectations follow RNS_MOD_ALU_AUTO_REDUCE_EN when it is defined.
module tb_rns_mod_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] op_sel;
  logic [3:0] add_a, sub_a, mul_a, zero_a, b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] result;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  rns_mod_alu #(.MOD(13), .W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel),
    .add_a(add_a), .sub_a(sub_a), .mul_a(mul_a), .zero_a(zero_a),
    .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .err(err)
  );

  always #5 clk = ~clk;

  task automatic do_op(input logic [1:0] op, input logic [3:0] a,
                       input logic [3:0] bv, output logic [3:0] res,
                       output logic e, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    op_sel   = op;
    add_a    = 4'($urandom);
    sub_a    = 4'($urandom);
    mul_a    = 4'($urandom);
    zero_a   = 4'($urandom);
    case (op)
      2'd0:    add_a  = a;
      2'd1:    sub_a  = a;
      2'd2:    mul_a  = a;
      default: zero_a = a;
    endcase
    b = bv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = result;
    e   = err;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hs in_ready=%b out_valid=%b want 1 0",
               in_ready, out_valid);
    end
    n_cmp++;
    if (result !== 4'd0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_out result=%0d err=%b want 0 0", result, err);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_rel in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_add();
    logic [3:0] r;
    logic e;
    int l;
    out_ready = 1'b1;
    do_op(2'd0, 4'd9, 4'd7, r, e, l);
    n_cmp++;
    if (r !== 4'd3 || e !== 1'b0) begin
      n_bad++;
      $display("FAIL add_9_7 result=%0d err=%b want 3 0", r, e);
    end
    n_cmp++;
    if (l !== 1) begin
      n_bad++;
      $display("FAIL add_lat got=%0d want 1", l);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL add_release in_ready=%b out_valid=%b want 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_sub();
    logic [3:0] r;
    logic e;
    int l;
    out_ready = 1'b1;
    do_op(2'd1, 4'd4, 4'd9, r, e, l);
    n_cmp++;
    if (r !== 4'd8 || e !== 1'b0 || l !== 1) begin
      n_bad++;
      $display("FAIL sub_4_9 result=%0d err=%b lat=%0d want 8 0 1", r, e, l);
    end
    do_op(2'd1, 4'd9, 4'd4, r, e, l);
    n_cmp++;
    if (r !== 4'd5 || e !== 1'b0 || l !== 1) begin
      n_bad++;
      $display("FAIL sub_9_4 result=%0d err=%b lat=%0d want 5 0 1", r, e, l);
    end
  endtask

  task automatic test_mul();
    logic [3:0] r;
    logic e;
    int l;
    out_ready = 1'b1;
    do_op(2'd2, 4'd7, 4'd6, r, e, l);
    n_cmp++;
    if (r !== 4'd3 || e !== 1'b0) begin
      n_bad++;
      $display("FAIL mul_7_6 result=%0d err=%b want 3 0", r, e);
    end
    n_cmp++;
    if (l !== 4) begin
      n_bad++;
      $display("FAIL mul_lat got=%0d want 4", l);
    end
    do_op(2'd2, 4'd12, 4'd12, r, e, l);
    n_cmp++;
    if (r !== 4'd1 || e !== 1'b0 || l !== 4) begin
      n_bad++;
      $display("FAIL mul_12_12 result=%0d err=%b lat=%0d want 1 0 4", r, e, l);
    end
  endtask

  task automatic test_reset_abort();
    logic [3:0] r;
    logic e;
    int l;
    int n;
    out_ready = 1'b1;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    op_sel   = 2'd2;
    mul_a    = 4'd7;
    b        = 4'd6;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_hs in_ready=%b out_valid=%b want 1 0",
               in_ready, out_valid);
    end
    n_cmp++;
    if (result !== 4'd0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_out result=%0d err=%b want 0 0", result, err);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_resume out_valid=%b want 0", out_valid);
    end
    do_op(2'd0, 4'd1, 4'd1, r, e, l);
    n_cmp++;
    if (r !== 4'd2 || e !== 1'b0 || l !== 1) begin
      n_bad++;
      $display("FAIL abort_add result=%0d err=%b lat=%0d want 2 0 1", r, e, l);
    end
  endtask

  task automatic test_zero_stall();
    logic [3:0] r;
    logic e;
    int l;
    out_ready = 1'b1;
    do_op(2'd3, 4'd5, 4'd5, r, e, l);
    n_cmp++;
    if (r !== 4'd0 || e !== 1'b0 || l !== 1) begin
      n_bad++;
      $display("FAIL zero_5_5 result=%0d err=%b lat=%0d want 0 0 1", r, e, l);
    end
    out_ready = 1'b0;
    do_op(2'd3, 4'd5, 4'd5, r, e, l);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hs cyc=%0d out_valid=%b in_ready=%b want 1 0",
                 i, out_valid, in_ready);
      end
      n_cmp++;
      if (result !== 4'd0 || err !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_out cyc=%0d result=%0d err=%b want 0 0",
                 i, result, err);
      end
      if (i == 1) begin
        in_valid = 1'b1;
        op_sel   = 2'd0;
        add_a    = 4'd1;
        b        = 4'd1;
      end
      if (i == 3) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_release in_ready=%b out_valid=%b want 1 0",
               in_ready, out_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_ignored out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_range();
    logic [3:0] r;
    logic e;
    int l;
    out_ready = 1'b1;
    do_op(2'd0, 4'd14, 4'd2, r, e, l);
`ifdef RNS_MOD_ALU_AUTO_REDUCE_EN
    n_cmp++;
    if (r !== 4'd3 || e !== 1'b0 || l !== 2) begin
      n_bad++;
      $display("FAIL range_reduce result=%0d err=%b lat=%0d want 3 0 2",
               r, e, l);
    end
`else
    n_cmp++;
    if (r !== 4'd0 || e !== 1'b1 || l !== 1) begin
      n_bad++;
      $display("FAIL range_err result=%0d err=%b lat=%0d want 0 1 1",
               r, e, l);
    end
`endif
    do_op(2'd0, 4'd3, 4'd4, r, e, l);
    n_cmp++;
    if (r !== 4'd7 || e !== 1'b0 || l !== 1) begin
      n_bad++;
      $display("FAIL range_after result=%0d err=%b lat=%0d want 7 0 1",
               r, e, l);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    op_sel    = 2'd0;
    add_a     = '0;
    sub_a     = '0;
    mul_a     = '0;
    zero_a    = '0;
    b         = '0;
    out_ready = 1'b1;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_reset_abort();
    test_zero_stall();
    test_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
